// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : score_display_ctrl
// Brief    : Generation/population score sequencer for a 4-digit 7-seg mux.
//            Optional SCORE_PAGE_TAG_EN: dig3 shows a page tag, 3-digit range.
// Revision : 1.0
// ============================================================================
module score_display_ctrl #(
    parameter int PAGE_CYCLES = 200000000,
    parameter int POP_W       = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen_inc,
    input  logic             gen_clr,
    input  logic [POP_W-1:0] pop_value,
    input  logic             pop_valid,
    output logic             pop_ready,
    input  logic             page_next,
    output logic             page,
    output logic             gen_sat,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3
);

`ifdef SCORE_PAGE_TAG_EN
    localparam int          c_sat_val = 999;
    localparam logic [15:0] c_sat_bcd = 16'h0999;
    localparam logic [15:0] c_dig_rst = 16'hA000;
`else
    localparam int          c_sat_val = 9999;
    localparam logic [15:0] c_sat_bcd = 16'h9999;
    localparam logic [15:0] c_dig_rst = 16'h0000;
`endif
    localparam int c_tw = $clog2(PAGE_CYCLES);
    localparam int c_cw = $clog2(POP_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        gen_q, gen_d;
    logic [15:0]        popbcd_q, popbcd_d;
    logic [15:0]        scr_q, scr_d;
    logic [POP_W-1:0]   bin_q, bin_d;
    logic [c_cw-1:0]    cnt_q, cnt_d;
    logic [c_tw-1:0]    timer_q, timer_d;
    logic               page_q, page_d;
    logic [15:0]        dig_q, dig_d;

    logic               w_gen_sat;
    logic               w_carry;
    logic [15:0]        w_adj;
    logic [POP_W-1:0]   w_pop_clamped;

    assign w_gen_sat = (gen_q == c_sat_bcd);

    // Decimal ripple increment; saturation blocks any further counting.
    always_comb begin
        gen_d   = gen_q;
        w_carry = 1'b1;
        if (gen_clr) begin
            gen_d = '0;
        end else if (gen_inc && !w_gen_sat) begin
            for (int i = 0; i < 4; i++) begin
                if (w_carry) begin
                    if (gen_q[4*i +: 4] == 4'd9) begin
                        gen_d[4*i +: 4] = 4'd0;
                    end else begin
                        gen_d[4*i +: 4] = gen_q[4*i +: 4] + 4'd1;
                        w_carry         = 1'b0;
                    end
                end
            end
        end
    end

    assign w_pop_clamped = (int'(pop_value) > c_sat_val) ? POP_W'(c_sat_val) : pop_value;

    always_comb begin
        w_adj = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        scr_d    = scr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        popbcd_d = popbcd_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_valid) begin
                    bin_d   = w_pop_clamped;
                    scr_d   = '0;
                    cnt_d   = c_cw'(POP_W);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                scr_d = {w_adj[14:0], bin_q[POP_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - c_cw'(1);
                if (cnt_q == c_cw'(1)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                popbcd_d = scr_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A button press on the terminal cycle merges into the single auto toggle.
    always_comb begin
        page_d  = page_q;
        timer_d = timer_q + c_tw'(1);
        if (page_next || (timer_q == c_tw'(PAGE_CYCLES - 1))) begin
            page_d  = ~page_q;
            timer_d = '0;
        end
    end

    always_comb begin
        dig_d = page_q ? popbcd_q : gen_q;
`ifdef SCORE_PAGE_TAG_EN
        dig_d[15:12] = page_q ? 4'd12 : 4'd10;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gen_q    <= '0;
            popbcd_q <= '0;
            scr_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            page_q   <= 1'b0;
            dig_q    <= c_dig_rst;
        end else begin
            state_q  <= state_d;
            gen_q    <= gen_d;
            popbcd_q <= popbcd_d;
            scr_q    <= scr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            page_q   <= page_d;
            dig_q    <= dig_d;
        end
    end

    assign pop_ready = (state_q == ST_IDLE);
    assign page      = page_q;
    assign gen_sat   = w_gen_sat;
    assign dig0      = dig_q[3:0];
    assign dig1      = dig_q[7:4];
    assign dig2      = dig_q[11:8];
    assign dig3      = dig_q[15:12];

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display_ctrl
// Brief    : Scoreboard bench for score_display_ctrl against a numeric model.
// Revision : 1.0
// ============================================================================
module tb_score_display_ctrl;
    localparam int PC = 8;
    localparam int PW = 14;
`ifdef SCORE_PAGE_TAG_EN
    localparam int SAT = 999;
    localparam bit TAG = 1'b1;
`else
    localparam int SAT = 9999;
    localparam bit TAG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gen_inc = 1'b0;
    logic          gen_clr = 1'b0;
    logic [PW-1:0] pop_value = '0;
    logic          pop_valid = 1'b0;
    logic          page_next = 1'b0;
    logic          pop_ready, page, gen_sat;
    logic [3:0]    dig0, dig1, dig2, dig3;

    always #5 clk = ~clk;

    score_display_ctrl #(.PAGE_CYCLES(PC), .POP_W(PW)) dut (
        .clk(clk), .reset(reset), .gen_inc(gen_inc), .gen_clr(gen_clr),
        .pop_value(pop_value), .pop_valid(pop_valid), .pop_ready(pop_ready),
        .page_next(page_next), .page(page), .gen_sat(gen_sat),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_digits(input int v, input bit pg);
        logic [15:0] r;
        r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        if (TAG) r[15:12] = pg ? 4'd12 : 4'd10;
        return r;
    endfunction

    // Numeric reference: integer counts, a busy countdown for conversion latency.
    int          m_gen = 0, m_pop = 0, m_page = 0, m_timer = 0, m_busy = 0, m_pend = 0;
    logic [15:0] e_dig = '0;
    bit          started = 1'b0;
    int          sb_q[$];

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_gen = 0; m_pop = 0; m_page = 0; m_timer = 0; m_busy = 0;
            sb_q.delete();
            e_dig = exp_digits(0, 1'b0);
        end else begin
            e_dig = exp_digits(m_page != 0 ? m_pop : m_gen, m_page != 0);
            if (gen_clr) m_gen = 0;
            else if (gen_inc && m_gen < SAT) m_gen++;
            if (page_next || m_timer == PC - 1) begin
                m_page = 1 - m_page;
                m_timer = 0;
            end else begin
                m_timer++;
            end
            if (m_busy == 0) begin
                if (pop_valid) begin
                    m_pend = (int'(pop_value) > SAT) ? SAT : int'(pop_value);
                    m_busy = PW + 1;
                    sb_q.push_back(m_pend);
                end
            end else begin
                m_busy--;
                if (m_busy == 0) m_pop = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("page", 32'(page), 32'(m_page));
            check("pop_ready", 32'(pop_ready), 32'(m_busy == 0));
            check("gen_sat", 32'(gen_sat), 32'(m_gen == SAT));
            check("digits", 32'({dig3, dig2, dig1, dig0}), 32'(e_dig));
        end
    end

    // Completed conversions: pop the expected value, compare once the pop page is shown.
    bit mon_busy = 1'b0;
    initial begin : monitor
        logic prev_ready;
        logic prev_page;
        int   expv;
        bit   ok;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (started && !reset && pop_ready === 1'b1 && prev_ready === 1'b0 && sb_q.size() > 0) begin
                expv     = sb_q.pop_front();
                ok       = 1'b0;
                mon_busy = 1'b1;
                for (int k = 0; k < 20 && !ok; k++) begin
                    prev_page = page;
                    @(negedge clk);
                    if (prev_page === 1'b1 && !reset) begin
                        check("pop_result", 32'({dig3, dig2, dig1, dig0}), 32'(exp_digits(expv, 1'b1)));
                        ok = 1'b1;
                    end
                end
                if (!ok) check("pop_result_timeout", 32'd0, 32'd1);
                mon_busy = 1'b0;
            end
            prev_ready = pop_ready;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_pop(input int v);
        int k;
        k = 0;
        while (pop_ready !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) check("pop_ready_wait", 32'd0, 32'd1);
        pop_value = PW'(v);
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
    endtask

    initial begin : stimulus
        int k;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_ready", 32'(pop_ready), 32'd1);
        check("reset_page", 32'(page), 32'd0);
        reset = 1'b0;

        gen_inc = 1'b1;
        repeat (1234) tick();
        gen_inc = 1'b0;
        tick();
        gen_inc = 1'b1; gen_clr = 1'b1;
        tick();
        gen_inc = 1'b0; gen_clr = 1'b0;
        tick();

        gen_inc = 1'b1;
        repeat (SAT - 1) tick();
        gen_inc = 1'b0;
        tick();
        repeat (3) begin
            gen_inc = 1'b1; tick();
            gen_inc = 1'b0; tick();
        end
        check("gen_sat_hold", 32'(gen_sat), 32'd1);
        repeat (4) tick();

        do_pop(4095);
        repeat (20) tick();
        do_pop(16383);
        repeat (20) tick();
        do_pop(500);
        pop_value = PW'(77);
        pop_valid = 1'b1;
        repeat (5) tick();
        pop_valid = 1'b0;
        repeat (25) tick();

        k = 0;
        while (m_timer != PC - 1 && k < 50) begin
            tick();
            k++;
        end
        page_next = 1'b1;
        tick();
        page_next = 1'b0;
        repeat (20) tick();

        repeat (10) tick();
        do_pop(321);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(pop_ready), 32'd1);
        repeat (20) tick();

        repeat (3000) begin
            gen_inc   = ($urandom % 2) == 0;
            gen_clr   = ($urandom % 200) == 0;
            pop_valid = ($urandom % 4) == 0;
            pop_value = (($urandom % 3) == 0) ? PW'($urandom_range(0, 999)) : PW'($urandom_range(0, 16383));
            page_next = (($urandom % 50) == 0) && !mon_busy;
            tick();
        end
        gen_inc = 1'b0; gen_clr = 1'b0; pop_valid = 1'b0; page_next = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
